// File: rtl/gate_and.sv
// Bitwise AND leaf element: combinational A & B plus a one-cycle registered copy
// with valid pulse, all-zero / all-ones flags and a set-bit count.
module gate_and #(
    parameter int N = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N-1:0]             A,
    input  logic [N-1:0]             B,
    input  logic                     in_valid,
    output logic [N-1:0]             F,
    output logic [N-1:0]             F_q,
    output logic                     out_valid,
    output logic                     all_zero_q,
    output logic                     all_ones_q,
    output logic [$clog2(N+1)-1:0]   ones_q
);

    localparam int CW = $clog2(N + 1);

    // Count of set bits; the count width holds the value N itself.
    function automatic logic [CW-1:0] popcount(input logic [N-1:0] v);
        logic [CW-1:0] cnt;
        cnt = {CW{1'b0}};
        for (int i = 0; i < N; i++) begin
            cnt = cnt + CW'(v[i]);
        end
        return cnt;
    endfunction

    logic [N-1:0]  and_s;
    logic          zero_s;
    logic          ones_flag_s;
    logic [CW-1:0] count_s;

    logic [N-1:0]  f_r;
    logic          valid_r;
    logic          zero_r;
    logic          ones_flag_r;
    logic [CW-1:0] count_r;

    // F is never gated by reset so X propagation follows plain four-state AND.
    assign and_s = A & B;
    assign F     = and_s;

    // Derive the flags and the count that get captured alongside the result.
    always_comb begin
        zero_s      = 1'b0;
        ones_flag_s = 1'b0;
        count_s     = popcount(and_s);
        if (and_s == {N{1'b0}}) begin
            zero_s = 1'b1;
        end else begin
            zero_s = 1'b0;
        end
        if (and_s == {N{1'b1}}) begin
            ones_flag_s = 1'b1;
        end else begin
            ones_flag_s = 1'b0;
        end
    end

    // Capture register: reset wins over in_valid; idle cycles hold data and drop valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_r         <= {N{1'b0}};
            valid_r     <= 1'b0;
            zero_r      <= 1'b0;
            ones_flag_r <= 1'b0;
            count_r     <= {CW{1'b0}};
        end else if (in_valid) begin
            f_r         <= and_s;
            valid_r     <= 1'b1;
            zero_r      <= zero_s;
            ones_flag_r <= ones_flag_s;
            count_r     <= count_s;
        end else begin
            valid_r     <= 1'b0;
        end
    end

    assign F_q        = f_r;
    assign out_valid  = valid_r;
    assign all_zero_q = zero_r;
    assign all_ones_q = ones_flag_r;
    assign ones_q     = count_r;

endmodule

// File: tb/tb_gate_and.sv
// Self-checking bench for gate_and at N=4, N=1 and N=32 against a behavioural model.
module tb_gate_and;

    logic clk = 1'b0;
    logic rst;

    logic [3:0]  a4, b4, f4, fq4;
    logic        iv4, ov4, az4, ao4;
    logic [2:0]  cnt4;

    logic [0:0]  a1, b1, f1, fq1;
    logic        iv1, ov1, az1, ao1;
    logic [0:0]  cnt1;

    logic [31:0] a32, b32, f32, fq32;
    logic        iv32, ov32, az32, ao32;
    logic [5:0]  cnt32;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] fq;
        logic        vld;
        logic        az;
        logic        ao;
        int          cnt;
    } model_t;

    model_t m4, m1, m32;

    gate_and #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .A(a4), .B(b4), .in_valid(iv4), .F(f4), .F_q(fq4),
        .out_valid(ov4), .all_zero_q(az4), .all_ones_q(ao4), .ones_q(cnt4)
    );

    gate_and #(.N(1)) dut1 (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .in_valid(iv1), .F(f1), .F_q(fq1),
        .out_valid(ov1), .all_zero_q(az1), .all_ones_q(ao1), .ones_q(cnt1)
    );

    gate_and #(.N(32)) dut32 (
        .clk(clk), .rst(rst), .A(a32), .B(b32), .in_valid(iv32), .F(f32), .F_q(fq32),
        .out_valid(ov32), .all_zero_q(az32), .all_ones_q(ao32), .ones_q(cnt32)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // What the registered path should hold after one edge, from the operation rules.
    function automatic model_t model_next(input model_t cur, input logic r, input logic iv,
                                          input logic [63:0] a, input logic [63:0] b, input int w);
        model_t      n;
        logic [63:0] mask;
        logic [63:0] p;
        n    = cur;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        p    = a & b & mask;
        if (r) begin
            n.fq = 64'd0; n.vld = 1'b0; n.az = 1'b0; n.ao = 1'b0; n.cnt = 0;
        end else if (iv) begin
            n.fq  = p;
            n.vld = 1'b1;
            n.az  = (p == 64'd0);
            n.ao  = (p == mask);
            n.cnt = $countones(p);
        end else begin
            n.vld = 1'b0;
        end
        return n;
    endfunction

    task automatic check_comb();
        check_value("n4.F",  64'(f4),  64'(a4) & 64'(b4));
        check_value("n1.F",  64'(f1),  64'(a1) & 64'(b1));
        check_value("n32.F", 64'(f32), 64'(a32) & 64'(b32));
    endtask

    // Advance one edge, update the model from the inputs applied, then compare.
    task automatic step();
        @(posedge clk);
        m4  = model_next(m4,  rst, iv4,  64'(a4),  64'(b4),  4);
        m1  = model_next(m1,  rst, iv1,  64'(a1),  64'(b1),  1);
        m32 = model_next(m32, rst, iv32, 64'(a32), 64'(b32), 32);
        #1;
        check_value("n4.F_q",       64'(fq4),  m4.fq);
        check_value("n4.out_valid", 64'(ov4),  64'(m4.vld));
        check_value("n4.all_zero",  64'(az4),  64'(m4.az));
        check_value("n4.all_ones",  64'(ao4),  64'(m4.ao));
        check_value("n4.ones_q",    64'(cnt4), 64'(m4.cnt));
        check_value("n1.F_q",       64'(fq1),  m1.fq);
        check_value("n1.out_valid", 64'(ov1),  64'(m1.vld));
        check_value("n1.all_zero",  64'(az1),  64'(m1.az));
        check_value("n1.all_ones",  64'(ao1),  64'(m1.ao));
        check_value("n1.ones_q",    64'(cnt1), 64'(m1.cnt));
        check_value("n32.F_q",      64'(fq32), m32.fq);
        check_value("n32.out_valid",64'(ov32), 64'(m32.vld));
        check_value("n32.all_zero", 64'(az32), 64'(m32.az));
        check_value("n32.all_ones", 64'(ao32), 64'(m32.ao));
        check_value("n32.ones_q",   64'(cnt32),64'(m32.cnt));
        check_comb();
    endtask

    // Directed N=4 stimulus: {A, B, in_valid}
    logic [8:0] dir_tbl [0:7];

    initial begin
        m4  = '{64'd0, 1'b0, 1'b0, 1'b0, 0};
        m1  = m4;
        m32 = m4;
        rst = 1'b1;
        a4 = 4'd0;  b4 = 4'd0;  iv4 = 1'b0;
        a1 = 1'b0;  b1 = 1'b0;  iv1 = 1'b0;
        a32 = 32'd0; b32 = 32'd0; iv32 = 1'b0;
        step();
        step();

        // Combinational cases, with explicit expected constants.
        a4 = 4'b1010; b4 = 4'b0101; #1; check_value("comb_1010_0101", 64'(f4), 64'd0);
        a4 = 4'b1100; b4 = 4'b1111; #1; check_value("comb_1100_1111", 64'(f4), 64'hc);
        a4 = 4'b0000; b4 = 4'b1111; #1; check_value("comb_0000_1111", 64'(f4), 64'd0);
        a4 = 4'b1x0x; b4 = 4'b0011; #1;
        check_value("comb_x_prop", {60'd0, f4}, {60'd0, 4'b000x});
        a4 = 4'b1x1x; b4 = 4'b1010; #1;
        check_value("comb_x_prop2", {60'd0, f4}, {60'd0, 4'b1x1x & 4'b1010});

        // Reset priority over in_valid; F keeps tracking during reset.
        a4 = 4'b1111; b4 = 4'b1111; iv4 = 1'b1; #1;
        check_value("comb_during_rst", 64'(f4), 64'hf);
        step();
        check_value("rst_prio_fq", 64'(fq4), 64'd0);

        rst = 1'b0;
        dir_tbl[0] = {4'b1111, 4'b1011, 1'b1};
        dir_tbl[1] = {4'b1111, 4'b1011, 1'b0};
        dir_tbl[2] = {4'b1111, 4'b1111, 1'b1};
        dir_tbl[3] = {4'b1010, 4'b0101, 1'b1};
        dir_tbl[4] = {4'b0001, 4'b1111, 1'b1};
        dir_tbl[5] = {4'b0011, 4'b1111, 1'b1};
        dir_tbl[6] = {4'b0111, 4'b1111, 1'b1};
        dir_tbl[7] = {4'b0000, 4'b0000, 1'b0};
        a1 = 1'b1; b1 = 1'b1; iv1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            {a4, b4, iv4} = dir_tbl[i];
            step();
        end
        check_value("n1_one_count", 64'(cnt1), 64'd1);

        // Reset mid-stream discards the same-edge capture.
        a4 = 4'b0110; b4 = 4'b1110; iv4 = 1'b1; iv1 = 1'b1; iv32 = 1'b1; rst = 1'b1;
        step();
        check_value("midstream_rst_valid", 64'(ov4), 64'd0);
        rst = 1'b0;
        step();
        check_value("after_rst_capture", 64'(fq4), 64'h6);

        // Randomized sweep across all widths.
        for (int i = 0; i < 1000; i++) begin
            a4   = 4'($urandom);  b4  = 4'($urandom);
            a1   = 1'($urandom);  b1  = 1'($urandom);
            a32  = $urandom;      b32 = $urandom;
            if (i % 4 == 1) begin
                b32 = 32'hffff_ffff;
                a32 = (i % 8 == 1) ? 32'hffff_ffff : a32;
            end
            iv4  = ($urandom_range(0, 3) != 0);
            iv1  = ($urandom_range(0, 3) != 0);
            iv32 = ($urandom_range(0, 3) != 0);
            rst  = ($urandom_range(0, 49) == 0);
            #1;
            check_comb();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gate_and.md
# gate_and

Parameterized bitwise AND block. Drives a combinational N-bit AND of two operand vectors, plus a one-cycle registered copy with a valid flag, reduction flags and a set-bit count. Used as a leaf datapath element wherever a masked operand is needed both immediately and pipeline-aligned.

## Interface

- Clocking: one clock; reset is synchronous and active-high.

Parameters:
- N, default 4, operand and result width in bits; legal range N >= 1.

Ports:
- clk  input  1  rising-edge clock for all registered outputs
- rst  input  1  synchronous active-high reset
- A  input  N  operand A
- B  input  N  operand B
- in_valid  input  1  qualifies A/B for capture into the registered path
- F  output  N  combinational result, A & B
- F_q  output  N  registered result
- out_valid  output  1  F_q/flags/count hold a freshly captured result
- all_zero_q  output  1  registered: captured result == 0
- all_ones_q  output  1  registered: captured result == all ones
- ones_q  output  $clog2(N+1)  registered: number of set bits in captured result

## Operation

- F = A & B, bit-for-bit: F[i] = A[i] & B[i] for every i in 0..N-1. Purely combinational, independent of clk, rst and in_valid.
- Unknown inputs follow standard four-state AND: 0 & X = 0, 1 & X = X. F must not be masked or forced by reset.
- Registered path, on each rising clk edge:
  - rst = 1: F_q <= 0, out_valid <= 0, all_zero_q <= 0, all_ones_q <= 0, ones_q <= 0. rst has priority over in_valid.
  - rst = 0, in_valid = 1: F_q <= A & B, all_zero_q <= (A & B == 0), all_ones_q <= (A & B == {N{1}}), ones_q <= popcount(A & B), out_valid <= 1.
  - rst = 0, in_valid = 0: F_q, all_zero_q, all_ones_q and ones_q hold their values; out_valid <= 0.
- ones_q width is $clog2(N+1), so the count N is representable. For N = 1 the width is 1.
- For N = 1, all_zero_q and all_ones_q are mutually exclusive complements whenever out_valid = 1.
- No backpressure. A new capture every cycle is legal.

## Timing

- F: zero-cycle latency. It settles within the same delta/timestep as any A or B change.
- Registered outputs: one-cycle latency. Values sampled at edge k appear after edge k and stay stable until the next capture or reset.
- out_valid is a one-cycle pulse per captured operand pair. Consecutive in_valid cycles give out_valid held high.
- Reset mid-stream: the capture in the same edge is discarded. out_valid is 0 on the following cycle. F keeps tracking A & B throughout.
- Reset values: F_q = 0, out_valid = 0, all_zero_q = 0, all_ones_q = 0, ones_q = 0. F has no reset value; it is combinational.

## Test plan

- Combinational, N=4, no clock activity:
  - A=1010, B=0101 -> F=0000 within 10 time units.
  - A=1100, B=1111 -> F=1100.
  - A=0000, B=1111 -> F=0000.
- Registered capture, N=4:
  - rst low, in_valid=1, A=1111, B=1011 at edge -> next cycle F_q=1011, ones_q=3, all_zero_q=0, all_ones_q=0, out_valid=1.
  - Next edge with in_valid=0 -> out_valid=0, F_q still 1011.
- Flags: A=B=1111 captured -> all_ones_q=1, ones_q=4. A=1010, B=0101 captured -> all_zero_q=1, ones_q=0.
- Reset priority: rst=1 and in_valid=1 on the same edge with A=B=1111 -> all registered outputs 0 next cycle. F=1111 combinationally throughout.
- Back-to-back stream: in_valid high for 3 edges with B=1111 and A=0001, 0011, 0111 -> F_q=0001, 0011, 0111 on successive cycles, ones_q=1, 2, 3, out_valid continuously 1.
- Width sweep: N=1 (A=1, B=1 -> F=1, ones_q=1) and N=32 with random A/B. Check F == A & B and ones_q == popcount(A & B) for 1000 vectors.
